// File: rtl/line_data_memory_pkg.sv
// Shared constants, FSM state type and address helpers for the line-granular
// data memory behind the data cache.
package mem_line_pkg;

    localparam int unsigned LINE_W      = 256;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned LINE_BYTES  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    function automatic logic [63:0] line_index(input logic [63:0] addr);
        return addr >> OFFSET_BITS;
    endfunction

endpackage

// File: rtl/line_data_memory_if.sv
// Cache-to-memory line bus: request (enable/write/addr/data) and
// completion (ack/data/err).
interface line_data_memory_if #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
);
    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
    logic              err_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, err_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, err_o
    );
endinterface

// File: rtl/line_data_memory_line_ram.sv
// Single-port synchronous line RAM; registered read with write-first bypass.
module line_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 256,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
            rdata       <= wdata;
        end else begin
            rdata <= r_mem[addr];
        end
    end
endmodule

// File: rtl/line_data_memory.sv
// Line-granular backing data memory with a fixed request-to-ack latency
// and out-of-range flagging.
module line_data_memory #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    line_data_memory_if.slave   bus
);
    import mem_line_pkg::*;

    localparam int unsigned ROW_W    = $clog2(DEPTH);
    localparam logic [5:0]  CNT_LOAD = 6'(LATENCY - 1);

    state_e            r_state;
    logic [5:0]        r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_ack;
    logic              r_err;
    logic [LINE_W-1:0] r_data;

    logic [63:0]       w_idx;
    logic              w_in_range;
    logic              w_access;
    logic              w_accept;
    logic [ROW_W-1:0]  w_row;
    logic [LINE_W-1:0] w_rdata;

    assign w_idx      = line_index(64'(r_addr));
    assign w_in_range = (w_idx < 64'(DEPTH));
    assign w_access   = (r_state == BUSY) && (r_cnt == '0);
    assign w_accept   = bus.enable_i && ((r_state == IDLE) || (r_state == ACK));
    assign w_row      = w_access ? w_idx[ROW_W-1:0] : '0;

    line_ram #(
        .DEPTH (DEPTH),
        .WIDTH (LINE_W)
    ) u_ram (
        .clk   (clk_i),
        .we    (w_access && r_write && w_in_range),
        .addr  (w_row),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) begin
                r_write <= bus.write_i;
                r_addr  <= bus.addr_i;
                r_wdata <= bus.data_i;
                r_cnt   <= CNT_LOAD;
            end
            case (r_state)
                IDLE: if (bus.enable_i) r_state <= BUSY;
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_err   <= !w_in_range;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                ACK: begin
                    // RAM output is only valid during ACK, so capture it for the hold phase
                    if (!r_write) r_data <= w_in_range ? w_rdata : '0;
                    r_state <= bus.enable_i ? BUSY : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ack_o  = r_ack;
    assign bus.err_o  = r_err;
    assign bus.data_o = ((r_state == ACK) && !r_write) ? (w_in_range ? w_rdata : '0) : r_data;

endmodule

// File: tb/tb_line_data_memory.sv
// Scoreboard bench for line_data_memory: a LATENCY=10 instance and a
// LATENCY=1 instance, with expected ack cycle/data/err queued at issue time.
module tb_line_data_memory;
    import mem_line_pkg::*;

    localparam int unsigned LAT0  = 10;
    localparam int unsigned LAT1  = 1;
    localparam int unsigned DEPTH = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_data_memory_if #(.LINE_W(256), .ADDR_W(32)) bus0 ();
    line_data_memory_if #(.LINE_W(256), .ADDR_W(32)) bus1 ();

    line_data_memory #(.LINE_W(256), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0)
    );

    line_data_memory #(.LINE_W(256), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        int           ack_cyc;
        logic [255:0] data;
        logic         err;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [255:0] model [int];
    logic [255:0] last_rd [2];
    int           n_chk  = 0;
    int           n_pass = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic ack_of(input int d);
        return (d == 0) ? bus0.ack_o : bus1.ack_o;
    endfunction

    task automatic set_bus(input int d, input logic en, input logic wr,
                           input logic [31:0] a, input logic [255:0] wd);
        if (d == 0) begin
            bus0.enable_i = en; bus0.write_i = wr; bus0.addr_i = a; bus0.data_i = wd;
        end else begin
            bus1.enable_i = en; bus1.write_i = wr; bus1.addr_i = a; bus1.data_i = wd;
        end
    endtask

    // Called at a negedge; returns at the negedge where ack_o is seen.
    task automatic issue(input int d, input logic wr, input logic [31:0] a,
                         input logic [255:0] wd, input bit hold, input bit scramble,
                         output int ack_cyc);
        int   idx;
        bit   inr;
        int   lat;
        exp_t e;
        idx = int'(a >> 5);
        inr = (idx < int'(DEPTH));
        lat = (d == 0) ? int'(LAT0) : int'(LAT1);
        e.ack_cyc = cyc + 1 + lat;
        e.err     = !inr;
        if (wr) begin
            if (inr) model[d * 4096 + idx] = wd;
            e.data = last_rd[d];
        end else begin
            e.data     = inr ? model[d * 4096 + idx] : '0;
            last_rd[d] = e.data;
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        set_bus(d, 1'b1, wr, a, wd);
        ack_cyc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (scramble && n == 3) set_bus(d, 1'b1, wr, a ^ 32'h20, ~wd);
            if (ack_of(d) === 1'b1) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) check("ack_timeout", 0, 1);
        if (!hold) set_bus(d, 1'b0, wr, a, wd);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus0.ack_o === 1'b1) begin
            if (q0.size() == 0) check("unexp_ack0", 1, 0);
            else begin
                e = q0.pop_front();
                check("ack_cyc0", cyc, e.ack_cyc);
                check("err0", bus0.err_o, e.err);
                check("data0", bus0.data_o, e.data);
            end
        end
        if (bus1.ack_o === 1'b1) begin
            if (q1.size() == 0) check("unexp_ack1", 1, 0);
            else begin
                e = q1.pop_front();
                check("ack_cyc1", cyc, e.ack_cyc);
                check("err1", bus1.err_o, e.err);
                check("data1", bus1.data_o, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int c, c1, c2, c3, acks;
        set_bus(0, 1'b0, 1'b0, '0, '0);
        set_bus(1, 1'b0, 1'b0, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", bus0.ack_o, 1'b0);
        check("rst_err", bus0.err_o, 1'b0);
        check("rst_data", bus0.data_o, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back
        issue(0, 1'b1, 32'h40, {32{8'hA5}}, 1'b0, 1'b0, c);
        issue(0, 1'b0, 32'h40, '0, 1'b0, 1'b0, c);

        // Offset bits ignored; neighbouring line distinct
        issue(0, 1'b1, 32'h80, {32{8'h44}}, 1'b0, 1'b0, c);
        issue(0, 1'b1, 32'h60, {32{8'h3C}}, 1'b0, 1'b0, c);
        issue(0, 1'b0, 32'h7C, '0, 1'b0, 1'b0, c);
        issue(0, 1'b0, 32'h80, '0, 1'b0, 1'b0, c);

        // Out of range: read returns 0 with err, write dropped (no alias into row 0)
        issue(0, 1'b1, 32'h0, {32{8'h0F}}, 1'b0, 1'b0, c);
        issue(0, 1'b0, 32'h4000, '0, 1'b0, 1'b0, c);
        issue(0, 1'b1, 32'h4000, {32{8'hEE}}, 1'b0, 1'b0, c);
        issue(0, 1'b0, 32'h0, '0, 1'b0, 1'b0, c);
        issue(0, 1'b1, 32'h100, {16{16'h1234}}, 1'b0, 1'b0, c);

        // Back-to-back with enable held; inputs scrambled during BUSY
        issue(0, 1'b1, 32'h200, {32{8'hB1}}, 1'b1, 1'b1, c1);
        issue(0, 1'b1, 32'h220, {32{8'hB2}}, 1'b1, 1'b1, c2);
        issue(0, 1'b1, 32'h240, {32{8'hB3}}, 1'b0, 1'b1, c3);
        check("b2b_gap1", c2 - c1, LAT0 + 1);
        check("b2b_gap2", c3 - c2, LAT0 + 1);
        issue(0, 1'b0, 32'h200, '0, 1'b0, 1'b0, c);
        issue(0, 1'b0, 32'h220, '0, 1'b0, 1'b0, c);
        issue(0, 1'b0, 32'h240, '0, 1'b0, 1'b0, c);

        // Reset during a write aborts it without ack
        set_bus(0, 1'b1, 1'b1, 32'h100, '1);
        acks = 0;
        repeat (5) @(negedge clk) acks += int'(ack_of(0));
        rst_n = 1'b0;
        set_bus(0, 1'b0, 1'b0, 32'h100, '0);
        repeat (3) @(negedge clk) acks += int'(ack_of(0));
        rst_n = 1'b1;
        repeat (12) @(negedge clk) acks += int'(ack_of(0));
        check("rst_mid_no_ack", acks, 0);
        check("rst_mid_data", bus0.data_o, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        issue(0, 1'b0, 32'h100, '0, 1'b0, 1'b0, c);

        // LATENCY=1 instance; data_o holds across a write ack
        issue(1, 1'b1, 32'h40, {32{8'h71}}, 1'b0, 1'b0, c);
        issue(1, 1'b0, 32'h40, '0, 1'b0, 1'b0, c);
        issue(1, 1'b1, 32'h60, {32{8'h72}}, 1'b0, 1'b0, c);
        issue(1, 1'b0, 32'h60, '0, 1'b0, 1'b0, c);
        issue(1, 1'b0, 32'h4000, '0, 1'b0, 1'b0, c);

        repeat (5) @(negedge clk);
        check("sb_empty", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/line_data_memory.md
Name: line_data_memory

Overview:
- Backing data memory on the data side of the pipelined CPU, directly downstream of the data cache.
- Serves whole 256-bit cache lines (fills and write-backs) over the cache's memory interface: enable/write/addr/data in, ack/data out.
- Models a fixed multi-cycle access latency through a small FSM, so the cache stall path and MEM-stage hold are exercised realistically.
- Flags accesses outside the implemented range.

Parameters:
- LINE_W, 256, line width in bits (32 bytes).
- ADDR_W, 32, byte address width.
- DEPTH, 512, number of lines implemented (16 KiB).
- LATENCY, 10, number of clock edges from request acceptance to ack; legal range 1..63.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- enable_i  in  1  request valid; held by the requester until ack_o is seen.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  ADDR_W  byte address; bits [4:0] are ignored.
- data_i  in  LINE_W  write line data.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read line data; valid while ack_o=1 for a read.
- err_o  out  1  pulses with ack_o when the line index is >= DEPTH.

Behaviour:
- Line index is idx = addr_i[ADDR_W-1:5]. In range when idx < DEPTH. The storage row is idx[log2(DEPTH)-1:0].
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: latency countdown in progress.
  - ACK: completion cycle.
- Reset (rst_i=0, asynchronous):
  - state=IDLE, ack_o=0, err_o=0, data_o=0, counter=0, request latches cleared.
  - Storage array is not reset; its contents are undefined until written.
- IDLE with enable_i=1 at an edge:
  - Latch addr_i, data_i and write_i.
  - Load counter with LATENCY-1 and move to BUSY.
  - With LATENCY=1, move straight to the access step below on the next edge.
- IDLE with enable_i=0: stay in IDLE.
- BUSY:
  - Decrement the counter each edge; input changes are ignored (the latched request is used).
  - On the edge where the counter is 0, perform the access:
    - In-range write: store the latched data into the row.
    - In-range read: load the row into data_o.
    - Out-of-range write: dropped.
    - Out-of-range read: data_o loaded with 0.
  - After the access, move to ACK with ack_o=1 and err_o=!in_range.
- ACK: lasts exactly one cycle. On the next edge: ack_o=0, err_o=0, move to IDLE.
- Timing: a request sampled at edge k produces ack_o high during the cycle following edge k+LATENCY. It cannot be re-accepted before edge k+LATENCY+1.
- Back-to-back requests: a request present at the edge that leaves ACK is accepted on that same edge. Minimum issue spacing is LATENCY+1 cycles.
- data_o holds its value after ack until the next read access completes. Writes do not change data_o.
- Read after write to the same line returns the new data.
- Reset asserted mid-operation aborts the request: no write is performed if the access edge has not yet occurred, and no ack is issued.
- Counter width is 6 bits.

Decomposition:
- Package mem_line_pkg:
  - LINE_W, OFFSET_BITS=5, LINE_BYTES=32.
  - State enum {IDLE, BUSY, ACK}.
  - Function line_index(addr).
- Sub-module line_ram: single-port synchronous RAM, DEPTH x LINE_W.
  - Ports: clk, we, addr, wdata, rdata.
  - Read data is registered, with write-first behaviour.
  - Instantiated once; the FSM drives we/addr only in the access cycle.

Test Plan:
1. Write then read, LATENCY=10:
   - Write line 0xA5A5...A5 to 0x0000_0040 (enable held from edge 0) -> ack_o high exactly in the cycle after edge 10, err_o=0.
   - Then read 0x0000_0040 -> data_o = 0xA5A5...A5 during ack.
2. Offset ignored / aliasing:
   - Write to 0x0000_0060, read 0x0000_007C -> same line returned.
   - Read 0x0000_0080 (index 4, never written except as preloaded) -> distinct data.
3. Out of range:
   - Read 0x0000_4000 (idx 512, DEPTH=512) -> data_o=0, err_o=1 with ack_o.
   - Write to same address, then read line 0 -> line 0 unchanged.
4. Back-to-back:
   - Hold enable_i=1 across three requests, changing addr/data only after each ack -> three acks spaced exactly 11 cycles apart.
   - Input changes during BUSY do not affect the stored data.
5. Reset mid-write:
   - Start write of 0xFFFF...F to 0x100, drop rst_i low at cycle 5 -> no ack_o.
   - After release, read 0x100 -> prior contents (0x1234 pattern written earlier).
6. LATENCY=1 sweep:
   - Read request at edge k -> ack_o in the cycle after edge k+1.
   - data_o stays stable through a following write ack.
